// File: rtl/sr_pkg.sv
// Shared constants and helpers for the SR flip-flop bank.
package sr_pkg;

  // Resolution of a simultaneous set and reset request.
  localparam int SR_HOLD    = 0;
  localparam int SR_SET_DOM = 1;
  localparam int SR_RST_DOM = 2;
  localparam int SR_TOGGLE  = 3;

  // Widest bank supported; popcount operates on a vector this wide.
  localparam int SR_MAX_N   = 32;

  // Number of set bits in a 32-bit vector (0..32 fits in 6 bits).
  function automatic logic [5:0] popcount(input logic [SR_MAX_N-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < SR_MAX_N; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One clocked SR storage channel: next-state resolution, registered
// edge pulses and a sticky conflict flag.
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter int   MODE    = SR_HOLD,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic clr_conflict,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic conflict
);

  logic r_q;
  logic r_rise;
  logic r_fall;
  logic r_conflict;
  logic w_q_next;
  logic w_conflict_hit;

  assign w_conflict_hit = en & s & r;

  // Next channel state from the set/reset request and the build-time mode.
  always_comb begin
    // NOTE: default first so every path assigns w_q_next and no latch is inferred.
    w_q_next = r_q;
    if (en) begin
      case ({s, r})
        2'b10: w_q_next = 1'b1;
        2'b01: w_q_next = 1'b0;
        2'b11: begin
          if (MODE == SR_SET_DOM)      w_q_next = 1'b1;
          else if (MODE == SR_RST_DOM) w_q_next = 1'b0;
          else if (MODE == SR_TOGGLE)  w_q_next = ~r_q;
          else                         w_q_next = r_q;
        end
        default: w_q_next = r_q;
      endcase
    end
  end

  // State, edge pulses and sticky flag; reset wins over every request.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all registers sample pre-edge values together.
    if (rst) begin
      r_q        <= RST_VAL;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_rise     <= ~r_q & w_q_next;
      r_fall     <= r_q & ~w_q_next;
      // A new conflict in the same cycle as a clear keeps the flag set.
      r_conflict <= w_conflict_hit | (r_conflict & ~clr_conflict);
    end
  end

  assign q        = r_q;
  assign q_rise   = r_rise;
  assign q_fall   = r_fall;
  assign conflict = r_conflict;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N clocked SR channels with a shared saturating conflict counter.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int             N       = 4,
  parameter int             MODE    = SR_HOLD,
  parameter logic [N-1:0]   RST_VAL = {N{1'b0}},
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic             clr_conflict,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qn,
  output logic [N-1:0]     q_rise,
  output logic [N-1:0]     q_fall,
  output logic [N-1:0]     conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Sum is formed 6 bits wider than the counter so a full-bank hit
  // (up to 32) added to a saturated count can never wrap before clamping.
  localparam int SUM_W = CNT_W + 6;
  localparam logic [SUM_W-1:0] CNT_MAX = {6'b0, {CNT_W{1'b1}}};

  if (MODE < SR_HOLD || MODE > SR_TOGGLE) begin : g_bad_mode
    $error("sr_ff_bank: MODE must be in 0..3");
  end
  if (N < 1 || N > SR_MAX_N) begin : g_bad_n
    $error("sr_ff_bank: N must be in 1..32");
  end

  logic [N-1:0]     w_hits;
  logic [5:0]       w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] r_cnt;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sr_ff_cell #(
      .MODE    (MODE),
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s            (s[i]),
      .r            (r[i]),
      .clr_conflict (clr_conflict),
      .q            (q[i]),
      .q_rise       (q_rise[i]),
      .q_fall       (q_fall[i]),
      .conflict     (conflict[i])
    );
  end

  assign qn = ~q;

  assign w_hits = en ? (s & r) : '0;
  assign w_pop  = popcount(SR_MAX_N'(w_hits));
  assign w_sum  = {6'b0, r_cnt} + {{CNT_W{1'b0}}, w_pop};

  // Clamp the widened sum at the counter's maximum instead of wrapping.
  always_comb begin
    w_cnt_next = w_sum[CNT_W-1:0];
    if (w_sum > CNT_MAX) begin
      w_cnt_next = {CNT_W{1'b1}};
    end
  end

  // Conflict counter; only reset clears it, clr_conflict leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign conflict_cnt = r_cnt;

endmodule
